// File: rtl/freq_sched_pkg.sv
// -----------------------------------------------------------------------------
// freq_sched_pkg
// Shared definitions for the frequency scheduler / period-engine arbiter:
//   - state_t        : scheduler FSM encoding (IDLE=0, ISSUE=1, WAIT=2)
//   - FREQ_W         : width of one channel's requested-frequency field
//   - PERIOD_DEFAULT : period each channel reports after reset
// -----------------------------------------------------------------------------
package freq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int FREQ_W         = 16;
  localparam int PERIOD_DEFAULT = 2000;

endpackage

// File: rtl/freq_sched_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of pending_i at
// or above ptr_i, searching upward and wrapping past the top channel.
// Ports:
//   pending_i   [N_CH]  : request vector
//   ptr_i       [IDX_W] : search start position (0..N_CH-1)
//   gnt_o       [IDX_W] : granted channel index (valid with any_valid_o)
//   any_valid_o         : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
  import freq_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_o,
  output logic             any_valid_o
);

  localparam logic [IDX_W:0] NCH_EXT = (IDX_W+1)'(N_CH);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to channel ptr_i.
    dbl         = {pending_i, pending_i};
    rot         = N_CH'(dbl >> ptr_i);
    off         = '0;
    any_valid_o = 1'b0;
    // Descending scan: the lowest set offset is the last one written.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off         = IDX_W'(k);
        any_valid_o = 1'b1;
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NCH_EXT) begin
      sum = sum - NCH_EXT;
    end
    gnt_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/freq_sched_arbiter.sv
// -----------------------------------------------------------------------------
// freq_sched_arbiter
// Shares one start/done period engine among N_CH pulse-generator channels.
// Each channel's requested frequency is shadowed; a difference marks the
// channel pending. Pending channels are granted round-robin: a zero frequency
// is answered locally with period 0, otherwise the engine is started and its
// result stored as that channel's period.
//
// Optional feature: define FREQ_SCHED_TIMEOUT_EN to enable the WAIT watchdog
// and the timeout_err port.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   user_freq   : N_CH x 16-bit requested frequency (0 = channel off)
//   eng_start   : one-cycle engine dispatch pulse
//   eng_freq    : frequency presented to the engine, held while it works
//   eng_done    : one-cycle engine completion pulse
//   eng_period  : engine result, valid with eng_done
//   period_out  : N_CH x BIT_WIDTH latest period per channel
//   period_upd  : per-channel one-cycle pulse when period_out is written
//   timeout_err : sticky per-channel watchdog flag (macro builds only)
//   busy        : scheduler is not IDLE
// -----------------------------------------------------------------------------
module freq_sched_arbiter
  import freq_sched_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int BIT_WIDTH      = 32,
  parameter int DEFAULT_PERIOD = PERIOD_DEFAULT,
  parameter int TIMEOUT_CYC    = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*FREQ_W-1:0]    user_freq,
  output logic                      eng_start,
  output logic [FREQ_W-1:0]         eng_freq,
  input  logic                      eng_done,
  input  logic [BIT_WIDTH-1:0]      eng_period,
  output logic [N_CH*BIT_WIDTH-1:0] period_out,
  output logic [N_CH-1:0]           period_upd,
`ifdef FREQ_SCHED_TIMEOUT_EN
  output logic [N_CH-1:0]           timeout_err,
`endif
  output logic                      busy
);

  localparam int                   IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IDX_W-1:0]     LAST_CH = IDX_W'(N_CH - 1);
  localparam logic [BIT_WIDTH-1:0] DEF_P   = BIT_WIDTH'(DEFAULT_PERIOD);

  state_t                 state_q;
  logic [FREQ_W-1:0]      shadow_q [N_CH];
  logic [N_CH-1:0]        pending_q, pending_d;
  logic [N_CH-1:0]        chg, clr;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       gnt_q;
  logic [FREQ_W-1:0]      eng_freq_q;
  logic                   eng_start_q;
  logic [BIT_WIDTH-1:0]   period_q [N_CH];
  logic [N_CH-1:0]        period_upd_q;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_vld;
  logic [FREQ_W-1:0]      pick_freq;

`ifdef FREQ_SCHED_TIMEOUT_EN
  localparam int              CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wait_cnt_q;
  logic [N_CH-1:0]  timeout_err_q;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == LAST_CH) ? '0 : idx + IDX_W'(1);
  endfunction

  rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending_i   (pending_q),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (pick_idx),
    .any_valid_o (pick_vld)
  );

  always_comb begin
    chg = '0;
    for (int i = 0; i < N_CH; i++) begin
      chg[i] = (user_freq[FREQ_W*i +: FREQ_W] != shadow_q[i]);
    end
    clr = '0;
    if (state_q == ST_IDLE && pick_vld) begin
      clr[pick_idx] = 1'b1;
    end
    // A fresh change outranks the clear of the grant taken this cycle.
    pending_d = (pending_q & ~clr) | chg;
    pick_freq = shadow_q[pick_idx];
  end

  // Change detection: shadows follow the inputs one cycle behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < N_CH; i++) begin
        shadow_q[i] <= user_freq[FREQ_W*i +: FREQ_W];
      end
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      eng_freq_q   <= '0;
      eng_start_q  <= 1'b0;
      period_upd_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        period_q[i] <= DEF_P;
      end
`ifdef FREQ_SCHED_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= '0;
`endif
    end else begin
      eng_start_q  <= 1'b0;
      period_upd_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q <= pick_idx;
            if (pick_freq == '0) begin
              // Channel switched off: answer locally, engine stays free.
              period_q[pick_idx]     <= '0;
              period_upd_q[pick_idx] <= 1'b1;
              rr_ptr_q               <= wrap_inc(pick_idx);
            end else begin
              eng_freq_q  <= pick_freq;
              eng_start_q <= 1'b1;
              state_q     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
`ifdef FREQ_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (eng_done) begin
            period_q[gnt_q]     <= eng_period;
            period_upd_q[gnt_q] <= 1'b1;
            rr_ptr_q            <= wrap_inc(gnt_q);
            state_q             <= ST_IDLE;
          end
`ifdef FREQ_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == TO_LAST) begin
            // Engine gave no answer: flag the channel, keep its old period.
            timeout_err_q[gnt_q] <= 1'b1;
            rr_ptr_q             <= wrap_inc(gnt_q);
            state_q              <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_freq   = eng_freq_q;
  assign period_upd = period_upd_q;
  assign busy       = (state_q != ST_IDLE);

  for (genvar g = 0; g < N_CH; g++) begin : g_pout
    assign period_out[BIT_WIDTH*g +: BIT_WIDTH] = period_q[g];
  end

`ifdef FREQ_SCHED_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  // No watchdog in this build; TIMEOUT_CYC is still accepted so that
  // instantiations are identical with and without the feature.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

endmodule

// File: tb/tb_freq_sched_arbiter.sv
module tb_freq_sched_arbiter;

  localparam int N_CH = 4;
  localparam int BW   = 32;
  localparam int DEF  = 2000;
  localparam int TO   = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_CH*16-1:0]   user_freq;
  logic                 eng_start;
  logic [15:0]          eng_freq;
  logic                 eng_done;
  logic [BW-1:0]        eng_period;
  logic [N_CH*BW-1:0]   period_out;
  logic [N_CH-1:0]      period_upd;
  logic                 busy;
`ifdef FREQ_SCHED_TIMEOUT_EN
  logic [N_CH-1:0]      timeout_err;
`endif

  freq_sched_arbiter #(
    .N_CH           (N_CH),
    .BIT_WIDTH      (BW),
    .DEFAULT_PERIOD (DEF),
    .TIMEOUT_CYC    (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .user_freq   (user_freq),
    .eng_start   (eng_start),
    .eng_freq    (eng_freq),
    .eng_done    (eng_done),
    .eng_period  (eng_period),
    .period_out  (period_out),
    .period_upd  (period_upd),
`ifdef FREQ_SCHED_TIMEOUT_EN
    .timeout_err (timeout_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the scheduler.
  int unsigned   sh_m   [N_CH];
  bit            pend_m [N_CH];
  logic [BW-1:0] per_m  [N_CH];
  bit            to_m   [N_CH];
  int            ptr_m;
  int            infl_m = -1;
  int            age_m;
  int unsigned   infl_f;

  // Engine model and observation counters.
  bit            job;
  int            job_cnt;
  int unsigned   job_f;
  bit            mute = 1'b0;
  int            dly_lo = 1;
  int            dly_hi = 5;
  int            n_start;
  int            n_upd [N_CH];
  int unsigned   start_log [$];
  bit            last_start;

  function automatic logic [BW-1:0] eng_calc(input int unsigned f);
    return BW'(1000000 / f);
  endfunction

  task automatic set_freq(input int ch, input int unsigned f);
    user_freq[16*ch +: 16] = 16'(f);
  endtask

  task automatic clear_obs();
    n_start = 0;
    start_log.delete();
    for (int i = 0; i < N_CH; i++) n_upd[i] = 0;
  endtask

  // One clock: sample at the falling edge, update the model for the rising
  // edge just passed, compare, then drive the engine for the next edge.
  task automatic cycle();
    logic [N_CH-1:0] exp_upd;
    bit              exp_start;
    bit              timed_out;
    int              c;
    int unsigned     f;
    @(negedge clk);
    exp_upd   = '0;
    exp_start = 1'b0;
    timed_out = 1'b0;
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        sh_m[i] = 0; pend_m[i] = 1'b0; per_m[i] = BW'(DEF); to_m[i] = 1'b0;
      end
      ptr_m  = 0;
      infl_m = -1;
      chk("rst_eng_freq", eng_freq, 0);
    end else begin
      if (infl_m >= 0) begin
        age_m++;
        if (eng_done && age_m >= 2) begin
          per_m[infl_m]   = eng_period;
          exp_upd[infl_m] = 1'b1;
          ptr_m           = (infl_m + 1) % N_CH;
          infl_m          = -1;
        end
`ifdef FREQ_SCHED_TIMEOUT_EN
        else if (age_m - 1 == TO) begin
          to_m[infl_m] = 1'b1;
          ptr_m        = (infl_m + 1) % N_CH;
          infl_m       = -1;
          timed_out    = 1'b1;
        end
`endif
      end else begin
        c = -1;
        for (int k = N_CH - 1; k >= 0; k--) begin
          if (pend_m[(ptr_m + k) % N_CH]) c = (ptr_m + k) % N_CH;
        end
        if (c >= 0) begin
          pend_m[c] = 1'b0;
          if (sh_m[c] == 0) begin
            per_m[c]   = '0;
            exp_upd[c] = 1'b1;
            ptr_m      = (c + 1) % N_CH;
          end else begin
            infl_m    = c;
            infl_f    = sh_m[c];
            age_m     = 0;
            exp_start = 1'b1;
          end
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        f = user_freq[16*i +: 16];
        if (f != sh_m[i]) begin
          sh_m[i]   = f;
          pend_m[i] = 1'b1;
        end
      end
    end
    chk("eng_start", eng_start, exp_start);
    chk("period_upd", period_upd, exp_upd);
    chk("busy", busy, infl_m >= 0);
    if (infl_m >= 0) chk("eng_freq", eng_freq, infl_f);
    for (int i = 0; i < N_CH; i++) chk("period_out", period_out[BW*i +: BW], per_m[i]);
`ifdef FREQ_SCHED_TIMEOUT_EN
    for (int i = 0; i < N_CH; i++) chk("timeout_err", timeout_err[i], to_m[i]);
`endif
    if (eng_start) begin
      n_start++;
      start_log.push_back(eng_freq);
    end
    for (int i = 0; i < N_CH; i++) if (period_upd[i]) n_upd[i]++;
    last_start = eng_start;

    eng_done   = 1'b0;
    eng_period = $urandom;
    if (reset || timed_out) begin
      job = 1'b0;
    end else if (eng_start) begin
      job     = 1'b1;
      job_f   = eng_freq;
      job_cnt = $urandom_range(dly_hi, dly_lo);
    end else if (job && !mute) begin
      job_cnt--;
      if (job_cnt == 0) begin
        eng_done   = 1'b1;
        eng_period = eng_calc(job_f);
        job        = 1'b0;
      end
    end else if (!job && infl_m < 0 && $urandom_range(7, 0) == 0) begin
      eng_done = 1'b1;  // stray completion while idle
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_start(input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_start && n < maxc);
    chk("wait_start", last_start, 1);
  endtask

  task automatic do_reset(input bit late);
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    if (late) begin
      eng_done   = 1'b1;
      eng_period = 32'hDEAD;
    end
    cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nz;
    reset      = 1'b1;
    user_freq  = '0;
    eng_done   = 1'b0;
    eng_period = '0;
    do_reset(1'b0);
    run(3);

    // Single channel request from all-off.
    clear_obs();
    set_freq(2, 500);
    run(12);
    chk("t1_starts", n_start, 1);
    if (start_log.size() > 0) chk("t1_freq", start_log[0], 500);
    chk("t1_period", period_out[BW*2 +: BW], 2000);
    chk("t1_upd", n_upd[2], 1);

    // Four simultaneous changes are served 0,1,2,3 twice in a row.
    user_freq = '0;
    do_reset(1'b0);
    run(2);
    clear_obs();
    set_freq(0, 100); set_freq(1, 200); set_freq(2, 400); set_freq(3, 800);
    run(40);
    chk("t2a_count", start_log.size(), 4);
    if (start_log.size() == 4) begin
      chk("t2a_o0", start_log[0], 100); chk("t2a_o1", start_log[1], 200);
      chk("t2a_o2", start_log[2], 400); chk("t2a_o3", start_log[3], 800);
    end
    clear_obs();
    set_freq(0, 150); set_freq(1, 250); set_freq(2, 350); set_freq(3, 450);
    run(40);
    chk("t2b_count", start_log.size(), 4);
    if (start_log.size() == 4) begin
      chk("t2b_o0", start_log[0], 150); chk("t2b_o1", start_log[1], 250);
      chk("t2b_o2", start_log[2], 350); chk("t2b_o3", start_log[3], 450);
    end

    // Channel switched off while the engine works on another channel.
    set_freq(0, 1000);
    wait_start(10);
    chk("t3_freq", eng_freq, 1000);
    clear_obs();
    set_freq(1, 0);
    run(20);
    chk("t3_no_start", n_start, 0);
    chk("t3_period", period_out[BW*1 +: BW], 0);
    chk("t3_upd", n_upd[1], 1);

    // Frequency change while the job is in flight.
    dly_lo = 4; dly_hi = 4;
    run(5);
    clear_obs();
    set_freq(3, 250);
    wait_start(10);
    chk("t4_first", eng_freq, 250);
    run(2);
    set_freq(3, 300);
    run(30);
    chk("t4_starts", n_start, 2);
    chk("t4_upd", n_upd[3], 2);
    if (start_log.size() == 2) chk("t4_second", start_log[1], 300);
    chk("t4_period", period_out[BW*3 +: BW], eng_calc(300));
    dly_lo = 1; dly_hi = 5;

    // Reset in WAIT with a stale completion arriving afterwards.
    set_freq(0, 700);
    wait_start(10);
    run(1);
    do_reset(1'b1);
    for (int i = 0; i < N_CH; i++) chk("t5_rst_period", period_out[BW*i +: BW], DEF);
    nz = 0;
    for (int i = 0; i < N_CH; i++) if (user_freq[16*i +: 16] != 0) nz++;
    clear_obs();
    run(40);
    chk("t5_redispatch", n_start, nz);

    // Randomized traffic.
    for (int it = 0; it < 500; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        set_freq($urandom_range(N_CH - 1, 0),
                 ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(5000, 1));
      end
      if ($urandom_range(199, 0) == 0) do_reset(1'($urandom_range(1, 0)));
      cycle();
    end
    run(40);

`ifdef FREQ_SCHED_TIMEOUT_EN
    // Silent engine: watchdog flags each dispatched channel in turn.
    user_freq = '0;
    do_reset(1'b0);
    run(3);
    mute = 1'b1;
    clear_obs();
    set_freq(1, 1111);
    set_freq(2, 2222);
    run(45);
    chk("to_flag1", timeout_err[1], 1);
    chk("to_flag2", timeout_err[2], 1);
    chk("to_flag0", timeout_err[0], 0);
    chk("to_starts", n_start, 2);
    chk("to_period1", period_out[BW*1 +: BW], DEF);
    mute = 1'b0;
    run(5);
    do_reset(1'b0);
    chk("to_cleared", timeout_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
